reg_bank8: RTL and testbench
============================

# reg_bank8

Eight-entry, 32-bit write-staging register bank that sits directly upstream of the dual read mux tree. It accepts single-word writes over a valid/ready port, holds per-entry valid bits, and continuously presents all entries plus the valid mask to the downstream mux. It also provides its own registered read port for direct lookups: unwritten entries read back as a constant default.

## Interface
- DEPTH, 8, number of entries; fixed power of two; address width is 3.
- WIDTH, 32, bits per entry.
- DEFAULT, 42, value returned for a read of an invalid entry.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IN_wvalid  in  1  write request.
- OUT_wready  out  1  bank can accept a write.
- IN_waddr  in  3  write entry index.
- IN_wdata  in  WIDTH  write data.
- IN_clr  in  1  clear all valid bits; single-cycle pulse or level.
- IN_rvalid  in  1  read request.
- IN_raddr  in  3  read entry index.
- OUT_rvalid  out  1  read data valid, one cycle after request.
- OUT_rdata  out  WIDTH  read data.
- OUT_bank  out  DEPTH x WIDTH  packed entry contents; entry i at bits [i*WIDTH +: WIDTH]. Feeds the downstream mux tree.
- OUT_vmask  out  DEPTH  per-entry valid bits.
- OUT_count  out  4  number of valid entries, 0..8.

## Operation
- Storage: DEPTH x WIDTH data registers plus DEPTH valid flops.
- Write accept: `wr_fire = IN_wvalid && OUT_wready && !IN_clr`.
  - On `wr_fire`, entry[IN_waddr] <= IN_wdata and vmask[IN_waddr] <= 1.
  - Overwriting an already-valid entry replaces the data and leaves the count unchanged.
- OUT_wready is a registered flag.
  - 0 while rst is asserted.
  - 1 from the first rising edge after rst deasserts, then stays 1.
  - No backpressure otherwise.
- Clear: when IN_clr = 1, vmask <= 0 and count <= 0 at the next edge.
  - Data registers are not cleared.
  - Clear has priority: a write in the same cycle is dropped, even if wvalid and wready are both 1. Sources must retry it.
- Read: on IN_rvalid = 1, the bank captures the result at the edge.
  - Result is entry[IN_raddr] if vmask[IN_raddr] = 1, else DEFAULT.
  - OUT_rvalid <= IN_rvalid every cycle.
  - OUT_rdata holds its last value when no read is issued.
- Read/write same cycle, same address: the read returns the pre-write value and validity (read-before-write).
- Read/clear same cycle: the read sees the pre-clear vmask.
- Count: OUT_count is registered and always equals popcount(OUT_vmask).
  - Update per edge: +1 on a write to an invalid entry, 0 on overwrite, reset to 0 on clear.
- OUT_bank and OUT_vmask are driven directly from the registers; there is no output mux.

## Timing
- Reset values:
  - OUT_wready = 0, OUT_rvalid = 0, OUT_rdata = 0, OUT_vmask = 0, OUT_count = 0.
  - OUT_bank = all zeros (data registers reset to 0).
- Reset assertion is asynchronous and takes effect immediately mid-operation. Any in-flight read response is lost (OUT_rvalid goes to 0).
- Write-to-visibility latency: 1 cycle. A write fired at edge N is visible on OUT_bank/OUT_vmask/OUT_count after edge N.
- Read latency: 1 cycle. A request sampled at edge N gives OUT_rvalid/OUT_rdata valid after edge N.
- Back-to-back reads and back-to-back writes are accepted every cycle.
- No combinational path from any input to any output.

## Test plan
- Reset/startup: hold rst = 0 for 3 cycles, then release.
  - All outputs read 0 during reset.
  - OUT_wready = 1 after the first edge post-release.
  - A read of addr 5 returns 42 with OUT_rvalid = 1 one cycle later.
- Fill all entries: write 0x100+i to addr i for i = 0..7 on consecutive cycles.
  - OUT_count steps 1..8.
  - OUT_vmask ends at 0xFF.
  - OUT_bank entry 3 = 0x103.
  - Reads of addrs 0..7 return 0x100..0x107.
- Overwrite and same-cycle hazard: addr 2 holds 0x102; write 0xDEAD to addr 2 while reading addr 2 in the same cycle.
  - The read returns 0x102.
  - The next read returns 0xDEAD.
  - OUT_count stays 8.
- Clear priority: with the bank full, assert IN_clr together with a write of 0xBEEF to addr 4 and a read of addr 4.
  - The read returns 0x104.
  - Next cycle: OUT_vmask = 0, OUT_count = 0.
  - A read of addr 4 returns 42.
  - OUT_bank entry 4 still shows 0x104.
- Mid-operation reset: issue a read, then assert rst before the next edge.
  - OUT_rvalid drops to 0 immediately.
  - After release, the bank is empty and all reads return 42.

Source files
------------

// File: rtl/reg_bank8.sv
// reg_bank8: eight-entry write-staging register bank with per-entry valid bits,
// a registered lookup port and a flat view of all entries for the downstream
// read mux tree. Unwritten (invalid) entries read back as DEFAULT.
module reg_bank8 #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32,
    parameter int DEFAULT = 42
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   IN_wvalid,
    output logic                   OUT_wready,
    input  logic [2:0]             IN_waddr,
    input  logic [WIDTH-1:0]       IN_wdata,
    input  logic                   IN_clr,
    input  logic                   IN_rvalid,
    input  logic [2:0]             IN_raddr,
    output logic                   OUT_rvalid,
    output logic [WIDTH-1:0]       OUT_rdata,
    output logic [DEPTH*WIDTH-1:0] OUT_bank,
    output logic [DEPTH-1:0]       OUT_vmask,
    output logic [3:0]             OUT_count
);

    // Entry storage; flattened onto OUT_bank without any muxing.
    logic [WIDTH-1:0] entry [DEPTH];
    logic             wr_fire;

    // Clear outranks a write in the same cycle; the write is simply dropped.
    assign wr_fire = IN_wvalid && OUT_wready && !IN_clr;

    // Ready rises on the first edge after reset release and never falls again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_wready <= 1'b0;
        end else begin
            OUT_wready <= 1'b1;
        end
    end

    // Data registers: written on an accepted write, untouched by clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (wr_fire) begin
            entry[IN_waddr] <= IN_wdata;
        end
    end

    // Valid mask and count tracked together so count always matches the mask;
    // an overwrite of a valid entry leaves the count alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_vmask <= '0;
            OUT_count <= '0;
        end else if (IN_clr) begin
            OUT_vmask <= '0;
            OUT_count <= '0;
        end else if (wr_fire) begin
            OUT_vmask[IN_waddr] <= 1'b1;
            if (!OUT_vmask[IN_waddr]) begin
                OUT_count <= OUT_count + 4'd1;
            end
        end
    end

    // Lookup port samples pre-edge state, giving read-before-write and
    // pre-clear visibility; rdata holds when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_rvalid <= 1'b0;
            OUT_rdata  <= '0;
        end else begin
            OUT_rvalid <= IN_rvalid;
            if (IN_rvalid) begin
                OUT_rdata <= OUT_vmask[IN_raddr] ? entry[IN_raddr] : WIDTH'(DEFAULT);
            end
        end
    end

    // Pack entries for the downstream mux tree.
    always_comb begin
        OUT_bank = '0;
        for (int i = 0; i < DEPTH; i++) begin
            OUT_bank[i*WIDTH +: WIDTH] = entry[i];
        end
    end

endmodule

// File: tb/tb_reg_bank8.sv
// tb_reg_bank8: directed and randomized checks of reg_bank8 against an
// array-based reference model of the bank's contents and valid flags.
module tb_reg_bank8;

    logic         clk = 1'b0;
    logic         rst;
    logic         IN_wvalid;
    logic         OUT_wready;
    logic [2:0]   IN_waddr;
    logic [31:0]  IN_wdata;
    logic         IN_clr;
    logic         IN_rvalid;
    logic [2:0]   IN_raddr;
    logic         OUT_rvalid;
    logic [31:0]  OUT_rdata;
    logic [255:0] OUT_bank;
    logic [7:0]   OUT_vmask;
    logic [3:0]   OUT_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_data [8];
    bit          m_valid [8];
    bit          m_ready;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    reg_bank8 #(.DEPTH(8), .WIDTH(32), .DEFAULT(42)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_wvalid  (IN_wvalid),
        .OUT_wready (OUT_wready),
        .IN_waddr   (IN_waddr),
        .IN_wdata   (IN_wdata),
        .IN_clr     (IN_clr),
        .IN_rvalid  (IN_rvalid),
        .IN_raddr   (IN_raddr),
        .OUT_rvalid (OUT_rvalid),
        .OUT_rdata  (OUT_rdata),
        .OUT_bank   (OUT_bank),
        .OUT_vmask  (OUT_vmask),
        .OUT_count  (OUT_count)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic check_all(input string tag);
        logic [255:0] exp_bank;
        logic [7:0]   exp_mask;
        int           exp_cnt;
        exp_bank = '0;
        exp_mask = '0;
        exp_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bank[i*32 +: 32] = m_data[i];
            exp_mask[i]          = m_valid[i];
            if (m_valid[i]) exp_cnt++;
        end
        check({tag, ".wready"}, 256'(OUT_wready), 256'(m_ready));
        check({tag, ".rvalid"}, 256'(OUT_rvalid), 256'(m_rvalid));
        check({tag, ".rdata"},  256'(OUT_rdata),  256'(m_rdata));
        check({tag, ".vmask"},  256'(OUT_vmask),  256'(exp_mask));
        check({tag, ".count"},  256'(OUT_count),  256'(exp_cnt));
        check({tag, ".bank"},   OUT_bank,         exp_bank);
    endtask

    // Apply one cycle of stimulus, advance the model, check everything.
    task automatic cycle(input string tag, input bit wv, input int wa, input logic [31:0] wd,
                         input bit clr, input bit rv, input int ra);
        bit fire;
        IN_wvalid = wv;
        IN_waddr  = 3'(wa);
        IN_wdata  = wd;
        IN_clr    = clr;
        IN_rvalid = rv;
        IN_raddr  = 3'(ra);
        fire = wv && m_ready && !clr;
        @(posedge clk);
        #1;
        m_rvalid = rv;
        if (rv) m_rdata = m_valid[ra] ? m_data[ra] : 32'd42;
        if (clr) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end else if (fire) begin
            m_data[wa]  = wd;
            m_valid[wa] = 1'b1;
        end
        m_ready = 1'b1;
        check_all(tag);
    endtask

    initial begin
        rst       = 1'b0;
        IN_wvalid = 1'b0;
        IN_waddr  = '0;
        IN_wdata  = '0;
        IN_clr    = 1'b0;
        IN_rvalid = 1'b0;
        IN_raddr  = '0;
        model_reset();

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end
        rst = 1'b1;
        check_all("released");
        cycle("first_edge", 0, 0, 0, 0, 0, 0);
        cycle("read_empty5", 0, 0, 0, 0, 1, 5);
        check("read_empty5.const", 256'(OUT_rdata), 256'(32'd42));

        // Fill all entries
        for (int i = 0; i < 8; i++) begin
            cycle("fill", 1, i, 32'h100 + 32'(i), 0, 0, 0);
            check("fill.count_step", 256'(OUT_count), 256'(i + 1));
        end
        check("fill.vmask", 256'(OUT_vmask), 256'(8'hFF));
        check("fill.entry3", 256'(OUT_bank[3*32 +: 32]), 256'(32'h103));
        for (int i = 0; i < 8; i++) begin
            cycle("fill_read", 0, 0, 0, 0, 1, i);
            check("fill_read.const", 256'(OUT_rdata), 256'(32'h100 + 32'(i)));
        end

        // Overwrite with same-cycle read of the same address
        cycle("ovw", 1, 2, 32'hDEAD, 0, 1, 2);
        check("ovw.old", 256'(OUT_rdata), 256'(32'h102));
        cycle("ovw_next", 0, 0, 0, 0, 1, 2);
        check("ovw.new", 256'(OUT_rdata), 256'(32'hDEAD));
        check("ovw.count", 256'(OUT_count), 256'(8));

        // Clear beats a simultaneous write; read sees pre-clear state
        cycle("clr", 1, 4, 32'hBEEF, 1, 1, 4);
        check("clr.read", 256'(OUT_rdata), 256'(32'h104));
        check("clr.vmask", 256'(OUT_vmask), 256'(0));
        check("clr.count", 256'(OUT_count), 256'(0));
        cycle("clr_read", 0, 0, 0, 0, 1, 4);
        check("clr_read.default", 256'(OUT_rdata), 256'(32'd42));
        check("clr.entry4", 256'(OUT_bank[4*32 +: 32]), 256'(32'h104));

        // Refill a few entries, then reset mid-read
        cycle("pre_rst_w", 1, 3, 32'h1234_5678, 0, 0, 0);
        cycle("pre_rst_r", 0, 0, 0, 0, 1, 3);
        IN_rvalid = 1'b1;
        IN_raddr  = 3'd3;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all("async_rst_rel");
        for (int i = 0; i < 8; i++) begin
            cycle("post_rst_read", 0, 0, 0, 0, 1, i);
        end
        check("post_rst.default", 256'(OUT_rdata), 256'(32'd42));

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            cycle("rand",
                  bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)),
                  32'($urandom()),
                  ($urandom_range(0, 15) == 0),
                  bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
        end
        cycle("idle", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
